// File: rtl/step_clock_gen.sv
// rtl/step_clock_gen.sv - debounced single-step clock source for the CPU board top.
// Optional auto-repeat of a held button is enabled by defining STEP_AUTOREPEAT_EN.
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int PULSE_CYCLES    = 5000,
  parameter int REPEAT_CYCLES   = 50000000,
  parameter int COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               button,
  input  logic               enable,
  output logic               step_clk,
  output logic               step_pulse,
  output logic [COUNT_W-1:0] step_count,
  output logic               busy
);

`ifdef STEP_AUTOREPEAT_EN
  localparam int REP_MAX = REPEAT_CYCLES;
`else
  // Repeat timer is idle without auto-repeat; WAIT_REL only watches for release.
  localparam int REP_MAX = 1 + 0 * REPEAT_CYCLES;
`endif

  localparam int DP_MAX  = (DEBOUNCE_CYCLES > PULSE_CYCLES) ? DEBOUNCE_CYCLES : PULSE_CYCLES;
  localparam int CNT_MAX = (DP_MAX > REP_MAX) ? DP_MAX : REP_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LOAD    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LOAD   = CNT_W'(REP_MAX - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    HIGH     = 3'd2,
    WAIT_REL = 3'd3,
    DB_REL   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sync1_q, sync1_d;
  logic               btn_s_q, btn_s_d;
  logic               step_clk_q, step_clk_d;
  logic               step_pulse_q, step_pulse_d;
  logic [COUNT_W-1:0] step_count_q, step_count_d;
  logic               busy_q, busy_d;

  always_comb begin
    sync1_d = button;
    btn_s_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (btn_s_q && enable) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!btn_s_q)          state_d = IDLE;
        else if (cnt_q == '0)  state_d = HIGH;
        else                   cnt_d   = cnt_q - CNT_W'(1);
      end
      HIGH: begin
        if (cnt_q == '0)       state_d = WAIT_REL;
        else                   cnt_d   = cnt_q - CNT_W'(1);
      end
      WAIT_REL: begin
        if (!btn_s_q)          state_d = DB_REL;
`ifdef STEP_AUTOREPEAT_EN
        else if (cnt_q == '0)  state_d = HIGH;
        else                   cnt_d   = cnt_q - CNT_W'(1);
`endif
      end
      DB_REL: begin
        if (btn_s_q)           state_d = WAIT_REL;
        else if (cnt_q == '0)  state_d = IDLE;
        else                   cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state change restarts the single shared timer for the new state.
    if (state_d != state_q) begin
      case (state_d)
        DB_PRESS: cnt_d = DB_LOAD;
        HIGH:     cnt_d = PULSE_LOAD;
        WAIT_REL: cnt_d = REP_LOAD;
        DB_REL:   cnt_d = DB_LOAD;
        default:  cnt_d = '0;
      endcase
    end

    step_pulse_d = (state_d == HIGH) && (state_q != HIGH);
    step_clk_d   = (state_d == HIGH);
    busy_d       = (state_d != IDLE);
    step_count_d = step_count_q + COUNT_W'(step_pulse_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sync1_q      <= 1'b0;
      btn_s_q      <= 1'b0;
      step_clk_q   <= 1'b0;
      step_pulse_q <= 1'b0;
      step_count_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync1_q      <= sync1_d;
      btn_s_q      <= btn_s_d;
      step_clk_q   <= step_clk_d;
      step_pulse_q <= step_pulse_d;
      step_count_q <= step_count_d;
      busy_q       <= busy_d;
    end
  end

  assign step_clk   = step_clk_q;
  assign step_pulse = step_pulse_q;
  assign step_count = step_count_q;
  assign busy       = busy_q;

endmodule
